// File: rtl/mul_share_pkg.sv
// Shared types for the multiplier-sharing scheduler: FSM state encoding and id-width helper.
package mul_share_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // A single requester still needs a 1-bit id field.
    function automatic int calc_idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mul_rr_arbiter.sv
// Round-robin arbiter: grants the first active request at or after i_ptr, wrapping at NREQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is consumed.
module mul_rr_arbiter import mul_share_pkg::*; #(
    parameter  int NREQ = 4,
    localparam int IDW  = calc_idw(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_gnt_id
);

    logic [IDW:0]   w_sum;
    logic [IDW-1:0] w_idx;
    logic           w_found;

    // i_ptr < NREQ and k < NREQ, so one conditional subtract performs the modulo.
    always_comb begin
        o_gnt    = '0;
        o_gnt_id = '0;
        w_sum    = '0;
        w_idx    = '0;
        w_found  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, i_ptr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(NREQ)) begin
                w_sum = w_sum - (IDW+1)'(NREQ);
            end
            w_idx = w_sum[IDW-1:0];
            if (!w_found && i_req[w_idx]) begin
                w_found      = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_gnt_id     = w_idx;
            end
        end
    end

endmodule

// File: rtl/mul_share_sched.sv
// Shares one sequential multiplier among NREQ requesters with round-robin grant and id-tagged responses.
// Latency: accept edge, one ISSUE cycle, then WAIT until mul_ready; response held in RESP.
// Backpressure: req_ready only in IDLE; RESP holds id/product until rsp_ready.
module mul_share_sched import mul_share_pkg::*; #(
    parameter  int W    = 8,
    parameter  int NREQ = 4,
    localparam int IDW  = calc_idw(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [2*W-1:0]    rsp_product,
    output logic              busy,
    output logic              mul_start,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    input  logic [2*W-1:0]    mul_product,
    input  logic              mul_ready
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  r_id;
    logic [W-1:0]    r_mul_a;
    logic [W-1:0]    r_mul_b;
    logic [2*W-1:0]  r_product;
    logic [NREQ-1:0] w_gnt;
    logic [IDW-1:0]  w_gnt_id;
    logic [W-1:0]    w_sel_a;
    logic [W-1:0]    w_sel_b;
    logic            w_accept;

    mul_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .i_req    (req_valid),
        .i_ptr    (r_rr_ptr),
        .o_gnt    (w_gnt),
        .o_gnt_id (w_gnt_id)
    );

    assign w_accept = (r_state == IDLE) && (|w_gnt);

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_a = req_a[i*W +: W];
                w_sel_b = req_b[i*W +: W];
            end
        end
    end

    // mul_ready is only trusted in WAIT; in ISSUE it may still reflect the previous operation.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (|w_gnt) w_state_nxt = ISSUE;
            ISSUE:   w_state_nxt = WAIT;
            WAIT:    if (mul_ready) w_state_nxt = RESP;
            RESP:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_rr_ptr  <= '0;
            r_id      <= '0;
            r_mul_a   <= '0;
            r_mul_b   <= '0;
            r_product <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_mul_a  <= w_sel_a;
                r_mul_b  <= w_sel_b;
                r_id     <= w_gnt_id;
                r_rr_ptr <= (w_gnt_id == IDW'(NREQ-1)) ? '0 : w_gnt_id + 1'b1;
            end
            if (r_state == WAIT && mul_ready) begin
                r_product <= mul_product;
            end
        end
    end

    assign req_ready   = (r_state == IDLE) ? w_gnt : '0;
    assign mul_start   = (r_state == ISSUE);
    assign mul_a       = r_mul_a;
    assign mul_b       = r_mul_b;
    assign rsp_valid   = (r_state == RESP);
    assign rsp_id      = r_id;
    assign rsp_product = r_product;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_mul_share_sched.sv
// Scoreboard bench for mul_share_sched with a behavioural sequential multiplier attached.
module tb_mul_share_sched;

    localparam int W    = 8;
    localparam int NREQ = 4;

    logic            clk;
    logic            rst;
    logic [3:0]      req_valid;
    logic [3:0]      req_ready;
    logic [31:0]     req_a;
    logic [31:0]     req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [15:0]     rsp_product;
    logic            busy;
    logic            mul_start;
    logic [7:0]      mul_a;
    logic [7:0]      mul_b;
    logic [15:0]     mul_product;
    logic            mul_ready;

    mul_share_sched #(.W(W), .NREQ(NREQ)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .busy        (busy),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_product (mul_product),
        .mul_ready   (mul_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier: start clears the counter, ready once it has counted up to W. No reset.
    int          m_cnt = W;
    logic [15:0] m_prod = '0;
    always @(posedge clk) begin
        if (mul_start) begin
            m_cnt  <= 0;
            m_prod <= $signed({{8{mul_a[7]}}, mul_a}) * $signed({{8{mul_b[7]}}, mul_b});
        end else if (m_cnt < W) begin
            m_cnt <= m_cnt + 1;
        end
    end
    assign mul_ready   = (m_cnt == W);
    assign mul_product = m_prod;

    typedef struct {
        int          id;
        logic [15:0] p;
    } exp_t;

    exp_t        sb_q[$];
    int          exp_order[$];
    logic [15:0] exp_prod [4];
    bit          push_en  [4];
    int          checks   = 0;
    int          errors   = 0;
    int          n_starts = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every handshake.
    always @(negedge clk) begin
        exp_t e;
        if (mul_start) n_starts++;
        if (req_ready != 4'b0) begin
            chk("req_ready_onehot", 32'((req_ready & (req_ready - 4'd1)) == 4'd0), 32'd1);
        end
        if (rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp got id=%0d product=%0h expected none", rsp_id, rsp_product);
            end else begin
                e = sb_q.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_product", 32'(rsp_product), 32'(e.p));
            end
        end
    end

    task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
        req_a[id*8 +: 8] = a;
        req_b[id*8 +: 8] = b;
        exp_prod[id]     = p;
        push_en[id]      = 1'b1;
        req_valid[id]    = 1'b1;
    endtask

    // Watches grants; checks order against exp_order and pushes the expected response.
    task automatic collect(input int n, input bit oneshot, output int first_wait);
        int got;
        int budget;
        int id;
        got        = 0;
        budget     = 0;
        first_wait = -1;
        while (got < n && budget < 400) begin
            @(negedge clk);
            if (req_ready != 4'b0) begin
                id = 0;
                for (int i = 0; i < 4; i++) if (req_ready[i]) id = i;
                if (first_wait < 0) first_wait = budget;
                if (exp_order.size() == 0) begin
                    chk("grant_order", 32'(id), 32'hFFFF_FFFF);
                end else begin
                    chk("grant_order", 32'(id), 32'(exp_order.pop_front()));
                end
                if (push_en[id]) sb_q.push_back('{id: id, p: exp_prod[id]});
                got++;
                @(posedge clk); #1;
                if (oneshot) req_valid[id] = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
            budget++;
        end
        if (got < n) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout got=%0d grants expected=%0d", got, n);
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (sb_q.size() != 0 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        chk("drain_empty", 32'(sb_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int fw;
        int s0;
        bit seen;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_en[i]  = 1'b0;
            exp_prod[i] = '0;
        end
        apply_reset();

        // Reset state.
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mul_start", 32'(mul_start), 32'd0);
        chk("rst_mul_ab", {16'd0, mul_a, mul_b}, 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_product", 32'(rsp_product), 32'd0);
        @(posedge clk); #1;

        // Single op: -3 * 5 on requester 2, latency and single start pulse.
        s0 = n_starts;
        set_req(2, 8'hFD, 8'h05, 16'hFFF1);
        exp_order.push_back(2);
        collect(1, 1'b1, fw);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            if (rsp_valid) break;
            lat++;
        end
        chk("latency", 32'(lat), 32'd10);
        drain();
        chk("start_pulses", 32'(n_starts - s0), 32'd1);

        // All four requesters after reset: grants 0..3.
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            set_req(i, 8'(i * 3), 8'd2, 16'(i * 6));
            exp_order.push_back(i);
        end
        collect(4, 1'b1, fw);
        drain();

        // Fairness: 1 and 3 held valid continuously.
        set_req(1, 8'd1, 8'd1, 16'h0001);
        set_req(3, 8'd2, 8'd3, 16'h0006);
        exp_order.push_back(1);
        exp_order.push_back(3);
        exp_order.push_back(1);
        exp_order.push_back(3);
        collect(4, 1'b0, fw);
        req_valid = '0;
        drain();

        // Backpressure on -128 * -128, with requester 2 waiting behind it.
        rsp_ready = 1'b0;
        set_req(0, 8'h80, 8'h80, 16'h4000);
        exp_order.push_back(0);
        collect(1, 1'b1, fw);
        set_req(2, 8'hFF, 8'hFF, 16'h0001);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            if (rsp_valid) break;
            lat++;
        end
        chk("bp_valid_rise", 32'(rsp_valid), 32'd1);
        s0 = n_starts;
        for (int j = 0; j < 5; j++) begin
            if (j > 0) @(negedge clk);
            chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
            chk("bp_hold_product", 32'(rsp_product), 32'h4000);
            chk("bp_hold_id", 32'(rsp_id), 32'd0);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_no_start", 32'(n_starts - s0), 32'd0);
        @(posedge clk); #1;
        exp_order.push_back(2);
        collect(1, 1'b1, fw);
        chk("bp_idle_next_cycle", 32'(fw), 32'd0);
        drain();

        // Reset in the third WAIT cycle: 7 * 6 on requester 1 is discarded.
        set_req(1, 8'd7, 8'd6, 16'h002A);
        push_en[1] = 1'b0;
        exp_order.push_back(1);
        collect(1, 1'b1, fw);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_mul_start", 32'(mul_start), 32'd0);
        chk("mid_rst_mul_ab", {16'd0, mul_a, mul_b}, 32'd0);
        chk("mid_rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("mid_rst_rsp_product", 32'(rsp_product), 32'd0);
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("mid_rst_no_rsp", 32'(seen), 32'd0);
        @(posedge clk); #1;
        set_req(1, 8'd7, 8'd6, 16'h002A);
        exp_order.push_back(1);
        collect(1, 1'b1, fw);
        drain();

        // Edge operands: 127 * -127 and 0 * -1; pointer is at 2 so 3 wins first.
        set_req(0, 8'h7F, 8'h81, 16'hC0FF);
        set_req(3, 8'h00, 8'hFF, 16'h0000);
        exp_order.push_back(3);
        exp_order.push_back(0);
        collect(2, 1'b1, fw);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
